// File: rtl/lcd_page_arbiter_if.sv
// Bundles the page-source request/row bus, the LCD sequencer handshake and the
// status outputs of the LCD page arbiter into one connection.
interface lcd_page_arbiter_if;
    logic [2:0]   req;
    logic [383:0] row1_in;
    logic [383:0] row2_in;
    logic         lcd_busy;
    logic         lcd_ena;
    logic [127:0] lcd_row1;
    logic [127:0] lcd_row2;
    logic [2:0]   grant;
    logic [2:0]   done;
    logic         err;
    logic         active;

    // Side that owns the page sources and the sequencer model.
    modport master (
        output req, row1_in, row2_in, lcd_busy,
        input  lcd_ena, lcd_row1, lcd_row2, grant, done, err, active
    );

    // Side implemented by the arbiter.
    modport slave (
        input  req, row1_in, row2_in, lcd_busy,
        output lcd_ena, lcd_row1, lcd_row2, grant, done, err, active
    );
endinterface

// File: rtl/lcd_page_arbiter.sv
// Shares one 16x2 LCD write sequencer between alarm, status and menu page
// sources. Alarm has absolute priority, status/menu alternate round-robin,
// and the last good page is re-sent after REFRESH_US idle cycles.
module lcd_page_arbiter #(
    parameter int REFRESH_US  = 500000,
    parameter int START_TO_US = 8,
    parameter int BUSY_TO_US  = 20000
) (
    input logic              clk_1MHz,
    input logic              rst_n,
    lcd_page_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        ACK
    } state_t;

    localparam logic [19:0] REFRESH_LAST  = 20'(REFRESH_US - 1);
    localparam logic [19:0] START_TO_LAST = 20'(START_TO_US - 1);
    localparam logic [19:0] BUSY_TO_LAST  = 20'(BUSY_TO_US - 1);

    state_t       state;
    state_t       state_next;
    logic [2:0]   winner;
    logic         refresh_due;
    logic         err_pulse;
    logic [19:0]  idle_cnt;
    logic [19:0]  to_cnt;
    logic         rr_ptr;
    logic         have_page;
    logic         xfer_err;
    logic [2:0]   grant_q;
    logic [127:0] row1_q;
    logic [127:0] row2_q;

    // Winner selection: alarm first, then status/menu alternating on rr_ptr.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        winner = 3'b000;
        if (bus.req[0]) begin
            winner = 3'b001;
        end else if (bus.req[1] && bus.req[2]) begin
            winner = rr_ptr ? 3'b100 : 3'b010;
        end else if (bus.req[1]) begin
            winner = 3'b010;
        end else if (bus.req[2]) begin
            winner = 3'b100;
        end
    end

    assign refresh_due = have_page && (REFRESH_US != 0) && (idle_cnt == REFRESH_LAST);

    // State register; reset may abort a transfer at any point.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and timeout detection.
    always_comb begin
        state_next = state;
        err_pulse  = 1'b0;
        case (state)
            IDLE: begin
                if (winner != 3'b000 || refresh_due) state_next = START;
            end
            START: state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.lcd_busy) begin
                    state_next = WAIT_DONE;
                end else if (to_cnt == START_TO_LAST) begin
                    err_pulse  = 1'b1;
                    state_next = ACK;
                end
            end
            WAIT_DONE: begin
                if (!bus.lcd_busy) begin
                    state_next = ACK;
                end else if (to_cnt == BUSY_TO_LAST) begin
                    err_pulse  = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Row latch, grant, round-robin pointer, counters and page-valid flag.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            row1_q    <= '0;
            row2_q    <= '0;
            grant_q   <= '0;
            rr_ptr    <= 1'b0;
            have_page <= 1'b0;
            xfer_err  <= 1'b0;
            idle_cnt  <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    xfer_err <= 1'b0;
                    if (winner != 3'b000) begin
                        // A request beats a same-cycle refresh; the idle count restarts.
                        grant_q  <= winner;
                        idle_cnt <= '0;
                        if (winner[0]) begin
                            row1_q <= bus.row1_in[127:0];
                            row2_q <= bus.row2_in[127:0];
                        end else if (winner[1]) begin
                            row1_q <= bus.row1_in[255:128];
                            row2_q <= bus.row2_in[255:128];
                            rr_ptr <= ~rr_ptr;
                        end else begin
                            row1_q <= bus.row1_in[383:256];
                            row2_q <= bus.row2_in[383:256];
                            rr_ptr <= ~rr_ptr;
                        end
                    end else if (idle_cnt != REFRESH_LAST) begin
                        idle_cnt <= idle_cnt + 20'd1;
                    end
                end
                START: to_cnt <= '0;
                WAIT_BUSY: begin
                    to_cnt <= bus.lcd_busy ? 20'd0 : to_cnt + 20'd1;
                    if (err_pulse) xfer_err <= 1'b1;
                end
                WAIT_DONE: begin
                    to_cnt <= to_cnt + 20'd1;
                    if (err_pulse) xfer_err <= 1'b1;
                end
                ACK: begin
                    if (!xfer_err) have_page <= 1'b1;
                    grant_q  <= '0;
                    idle_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Start is suppressed while the sequencer still reports busy.
    assign bus.lcd_ena  = (state == START) && !bus.lcd_busy;
    assign bus.done     = (state == ACK) ? grant_q : 3'b000;
    assign bus.err      = err_pulse;
    assign bus.active   = (state != IDLE);
    assign bus.grant    = grant_q;
    assign bus.lcd_row1 = row1_q;
    assign bus.lcd_row2 = row2_q;

endmodule

// File: tb/tb_lcd_page_arbiter.sv
// Self-checking bench for lcd_page_arbiter: a transaction-level reference
// model predicts the winner, latched rows and refresh timing, while the bench
// plays the role of the LCD sequencer on lcd_busy.
`timescale 1ns/1ps
module tb_lcd_page_arbiter;

    localparam int REFRESH  = 100;
    localparam int START_TO = 8;
    localparam int BUSY_TO  = 60;

    logic clk_1MHz = 1'b0;
    logic rst_n    = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    // Reference model state.
    logic         m_rr;
    logic         m_have_page;
    logic [127:0] m_row1;
    logic [127:0] m_row2;

    always #5 clk_1MHz = ~clk_1MHz;

    lcd_page_arbiter_if bus ();

    lcd_page_arbiter #(
        .REFRESH_US (REFRESH),
        .START_TO_US(START_TO),
        .BUSY_TO_US (BUSY_TO)
    ) dut (
        .clk_1MHz(clk_1MHz),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, CHECKS %0d", checks);
        $fatal(1);
    end

    function automatic logic [383:0] rand384();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // Alarm wins outright; status/menu alternate, rr=0 favouring status.
    function automatic logic [2:0] model_pick(input logic [2:0] r, input logic rr);
        if (r[0])               return 3'b001;
        if (r[1] && r[2])       return rr ? 3'b100 : 3'b010;
        if (r[1])               return 3'b010;
        if (r[2])               return 3'b100;
        return 3'b000;
    endfunction

    task automatic apply_reset();
        rst_n        = 1'b0;
        bus.req      = 3'b000;
        bus.lcd_busy = 1'b0;
        bus.row1_in  = rand384();
        bus.row2_in  = rand384();
        repeat (3) @(negedge clk_1MHz);
        rst_n       = 1'b1;
        m_rr        = 1'b0;
        m_have_page = 1'b0;
        m_row1      = '0;
        m_row2      = '0;
    endtask

    // One complete transfer: predict, wait for start, model busy, check ACK.
    task automatic run_transfer(input string name, input int budget, input int busy_len,
                                input bit drop_req, output logic [2:0] obs_grant,
                                output int wait_cycles);
        logic [2:0] exp_grant;
        bit         seen;
        int         k;
        exp_grant = model_pick(bus.req, m_rr);
        if (exp_grant[1] || exp_grant[2]) m_rr = ~m_rr;
        if (exp_grant != 3'b000) begin
            k      = exp_grant[0] ? 0 : (exp_grant[1] ? 1 : 2);
            m_row1 = bus.row1_in[128*k +: 128];
            m_row2 = bus.row2_in[128*k +: 128];
        end
        seen        = 1'b0;
        wait_cycles = 0;
        obs_grant   = 3'bxxx;
        while (!seen && wait_cycles < budget) begin
            @(negedge clk_1MHz);
            wait_cycles++;
            if (bus.lcd_ena === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s start: lcd_ena not seen within %0d cycles", name, budget);
            return;
        end
        obs_grant = bus.grant;
        checks++;
        if (bus.grant !== exp_grant || bus.active !== 1'b1) begin
            errors++;
            $display("FAIL %s grant: got %b active %b, expected %b active 1",
                     name, bus.grant, bus.active, exp_grant);
        end
        checks++;
        if (bus.lcd_row1 !== m_row1 || bus.lcd_row2 !== m_row2) begin
            errors++;
            $display("FAIL %s rows: got %h/%h expected %h/%h",
                     name, bus.lcd_row1, bus.lcd_row2, m_row1, m_row2);
        end
        if (drop_req) bus.req = 3'b000;
        bus.lcd_busy = 1'b1;
        for (int i = 0; i < busy_len; i++) begin
            @(negedge clk_1MHz);
            checks++;
            if (bus.lcd_ena !== 1'b0 || bus.done !== 3'b000 || bus.err !== 1'b0 ||
                bus.lcd_row1 !== m_row1 || bus.lcd_row2 !== m_row2) begin
                errors++;
                $display("FAIL %s busy_window cycle %0d: ena %b done %b err %b row1 %h expected ena 0 done 000 err 0 row1 %h",
                         name, i, bus.lcd_ena, bus.done, bus.err, bus.lcd_row1, m_row1);
            end
            // Source rows may change freely once latched.
            bus.row1_in = rand384();
            bus.row2_in = rand384();
        end
        bus.lcd_busy = 1'b0;
        @(negedge clk_1MHz);
        checks++;
        if (bus.done !== exp_grant || bus.err !== 1'b0 || bus.active !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %b err %b active %b, expected %b err 0 active 1",
                     name, bus.done, bus.err, bus.active, exp_grant);
        end
        m_have_page = 1'b1;
        @(negedge clk_1MHz);
        checks++;
        if (bus.grant !== 3'b000 || bus.done !== 3'b000 || bus.active !== 1'b0) begin
            errors++;
            $display("FAIL %s after_ack: grant %b done %b active %b, expected 000 000 0",
                     name, bus.grant, bus.done, bus.active);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.req      = 3'b111;
        bus.lcd_busy = 1'b0;
        bus.row1_in  = rand384();
        bus.row2_in  = rand384();
        repeat (2) @(negedge clk_1MHz);
        checks++;
        if (bus.lcd_ena !== 1'b0 || bus.grant !== 3'b000 || bus.done !== 3'b000 ||
            bus.err !== 1'b0 || bus.active !== 1'b0 ||
            bus.lcd_row1 !== 128'd0 || bus.lcd_row2 !== 128'd0) begin
            errors++;
            $display("FAIL reset_state: ena %b grant %b done %b err %b active %b row1 %h row2 %h, expected all zero",
                     bus.lcd_ena, bus.grant, bus.done, bus.err, bus.active, bus.lcd_row1, bus.lcd_row2);
        end
    endtask

    task automatic test_single();
        logic [2:0] g;
        int         w;
        logic [127:0] status_text;
        apply_reset();
        status_text = "STATUS OK       ";
        bus.row1_in[255:128] = status_text;
        bus.req = 3'b010;
        run_transfer("single", 4, 40, 1'b1, g, w);
        checks++;
        if (g !== 3'b010 || w !== 1) begin
            errors++;
            $display("FAIL single_latency: grant %b after %0d cycles, expected 010 after 1", g, w);
        end
        checks++;
        if (m_row1 !== status_text) begin
            errors++;
            $display("FAIL single_text: model row %h expected %h", m_row1, status_text);
        end
    endtask

    task automatic test_priority();
        logic [2:0] g;
        int         w;
        logic [2:0] order [5];
        order = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
        apply_reset();
        bus.req = 3'b111;
        for (int i = 0; i < 5; i++) begin
            run_transfer("priority", 4, 3 + i, 1'b0, g, w);
            checks++;
            if (g !== order[i]) begin
                errors++;
                $display("FAIL priority_order step %0d: got %b expected %b", i, g, order[i]);
            end
            bus.req = 3'b110;
        end
        bus.req = 3'b000;
    endtask

    task automatic test_random();
        logic [2:0] g;
        int         w;
        for (int i = 0; i < 20; i++) begin
            bus.row1_in = rand384();
            bus.row2_in = rand384();
            bus.req     = 3'($urandom_range(1, 7));
            run_transfer("random", 4, $urandom_range(1, 30), 1'b1, g, w);
        end
    endtask

    // Refresh timing is measured from the first IDLE cycle after ACK.
    task automatic test_refresh();
        logic [2:0] g;
        int         w;
        bus.req     = 3'b000;
        bus.row1_in = rand384();
        bus.row2_in = rand384();
        run_transfer("refresh", REFRESH + 20, 10, 1'b1, g, w);
        checks++;
        if (w !== REFRESH || g !== 3'b000) begin
            errors++;
            $display("FAIL refresh_timing: lcd_ena after %0d cycles grant %b, expected %0d grant 000",
                     w, g, REFRESH);
        end
        // A request landing on the refresh cycle wins and the refresh is dropped.
        repeat (REFRESH - 1) @(negedge clk_1MHz);
        bus.req = 3'b100;
        run_transfer("refresh_collide", 3, 5, 1'b1, g, w);
        checks++;
        if (w !== 1 || g !== 3'b100) begin
            errors++;
            $display("FAIL refresh_collide: grant %b after %0d cycles, expected 100 after 1", g, w);
        end
        run_transfer("refresh_again", REFRESH + 20, 4, 1'b1, g, w);
        checks++;
        if (w !== REFRESH || g !== 3'b000) begin
            errors++;
            $display("FAIL refresh_again: lcd_ena after %0d cycles grant %b, expected %0d grant 000",
                     w, g, REFRESH);
        end
    endtask

    task automatic test_timeouts();
        bit seen;
        int k;
        int ena_count;
        // Sequencer never answers.
        apply_reset();
        bus.req = 3'b001;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 4) begin
            @(negedge clk_1MHz);
            k++;
            if (bus.lcd_ena === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || bus.grant !== 3'b001) begin
            errors++;
            $display("FAIL start_to_grant: seen %b grant %b, expected 1 001", seen, bus.grant);
        end
        bus.req = 3'b000;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < START_TO + 5) begin
            @(negedge clk_1MHz);
            k++;
            if (bus.err === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || k !== START_TO) begin
            errors++;
            $display("FAIL start_timeout: err seen %b after %0d cycles, expected after %0d", seen, k, START_TO);
        end
        @(negedge clk_1MHz);
        checks++;
        if (bus.done !== 3'b001 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL start_to_done: done %b err %b expected 001 0", bus.done, bus.err);
        end
        ena_count = 0;
        repeat (2 * REFRESH) begin
            @(negedge clk_1MHz);
            if (bus.lcd_ena === 1'b1) ena_count++;
        end
        checks++;
        if (ena_count !== 0) begin
            errors++;
            $display("FAIL start_to_no_refresh: %0d lcd_ena pulses, expected 0", ena_count);
        end

        // Sequencer goes busy and never finishes.
        bus.req = 3'b100;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 4) begin
            @(negedge clk_1MHz);
            k++;
            if (bus.lcd_ena === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || bus.grant !== 3'b100) begin
            errors++;
            $display("FAIL busy_to_grant: seen %b grant %b, expected 1 100", seen, bus.grant);
        end
        m_rr         = ~m_rr;
        bus.req      = 3'b000;
        bus.lcd_busy = 1'b1;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < BUSY_TO + 10) begin
            @(negedge clk_1MHz);
            k++;
            if (bus.err === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || k !== BUSY_TO + 1) begin
            errors++;
            $display("FAIL busy_timeout: err seen %b after %0d cycles, expected after %0d", seen, k, BUSY_TO + 1);
        end
        @(negedge clk_1MHz);
        checks++;
        if (bus.done !== 3'b100) begin
            errors++;
            $display("FAIL busy_to_done: done %b expected 100", bus.done);
        end
        bus.lcd_busy = 1'b0;
        ena_count = 0;
        repeat (REFRESH + 20) begin
            @(negedge clk_1MHz);
            if (bus.lcd_ena === 1'b1) ena_count++;
        end
        checks++;
        if (ena_count !== 0) begin
            errors++;
            $display("FAIL busy_to_no_refresh: %0d lcd_ena pulses, expected 0", ena_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] g;
        int         w;
        apply_reset();
        bus.req = 3'b010;
        @(negedge clk_1MHz);
        bus.lcd_busy = 1'b1;
        repeat (5) @(negedge clk_1MHz);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 3'b000 || bus.lcd_ena !== 1'b0 || bus.active !== 1'b0 ||
            bus.lcd_row1 !== 128'd0) begin
            errors++;
            $display("FAIL reset_mid: grant %b ena %b active %b row1 %h, expected 000 0 0 zero",
                     bus.grant, bus.lcd_ena, bus.active, bus.lcd_row1);
        end
        @(negedge clk_1MHz);
        bus.lcd_busy = 1'b0;
        rst_n        = 1'b1;
        m_rr         = 1'b0;
        m_have_page  = 1'b0;
        m_row1       = '0;
        m_row2       = '0;
        run_transfer("reset_restart", 4, 6, 1'b1, g, w);
        checks++;
        if (g !== 3'b010 || w !== 1) begin
            errors++;
            $display("FAIL reset_restart: grant %b after %0d cycles, expected 010 after 1", g, w);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_random();
        test_refresh();
        test_timeouts();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
